// File: rtl/store_sequence_checker.sv
// Store-sequence self-check monitor: compares CPU data-memory writes against a programmed
// ordered list of (addr,data) pairs, skipping ignored addresses, and reports pass/fail/timeout.
module store_sequence_checker #(
  parameter int WIDTH          = 32,
  parameter int NUM_EXPECT     = 8,
  parameter int NUM_IGNORE     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int TMAX = (NUM_EXPECT > NUM_IGNORE) ? NUM_EXPECT : NUM_IGNORE,
  localparam int IW   = (TMAX > 1) ? $clog2(TMAX) : 1,
  localparam int CW   = $clog2(NUM_EXPECT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  input  logic [CW-1:0]    exp_len,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CW-1:0]    match_count,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  localparam int EW = (NUM_EXPECT > 1) ? $clog2(NUM_EXPECT) : 1;
  localparam int GW = (NUM_IGNORE > 1) ? $clog2(NUM_IGNORE) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_BAD_DATA = 2'b01;
  localparam logic [1:0] FC_BAD_ADDR = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    len_q;
  logic [TW-1:0]    timer;

  logic [WIDTH-1:0] exp_addr [NUM_EXPECT];
  logic [WIDTH-1:0] exp_data [NUM_EXPECT];
  logic [WIDTH-1:0] ign_addr [NUM_IGNORE];
  logic [NUM_IGNORE-1:0] ign_valid;

  logic             cfg_ok;
  logic [CW-1:0]    len_clamped;
  logic [WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0] cur_data;
  logic             addr_hit;
  logic             data_hit;
  logic             ign_hit;
  logic             expire;

  assign cfg_ok      = cfg_we && (state != S_RUN);
  assign len_clamped = (int'(exp_len) > NUM_EXPECT) ? CW'(NUM_EXPECT) : exp_len;
  assign cur_addr    = exp_addr[match_count[EW-1:0]];
  assign cur_data    = exp_data[match_count[EW-1:0]];
  assign addr_hit    = (dataadr == cur_addr);
  assign data_hit    = (writedata == cur_data);
  assign expire      = (TIMEOUT_CYCLES != 0) && ((int'(timer) + 1) == TIMEOUT_CYCLES);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ign_hit = 1'b0;
    for (int i = 0; i < NUM_IGNORE; i++) begin
      if (ign_valid[i] && (ign_addr[i] == dataadr)) ign_hit = 1'b1;
    end
  end

  // NOTE: the expect table is plain storage with no reset, so it can map onto RAM; its contents
  // are meaningless until programmed.
  always_ff @(posedge clk) begin
    if (!reset && cfg_ok && !cfg_sel && (int'(cfg_idx) < NUM_EXPECT)) begin
      exp_addr[cfg_idx[EW-1:0]] <= cfg_addr;
      exp_data[cfg_idx[EW-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && cfg_ok && cfg_sel && (int'(cfg_idx) < NUM_IGNORE)) begin
      ign_addr[cfg_idx[GW-1:0]] <= cfg_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      timer       <= '0;
      ign_valid   <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FC_NONE;
      match_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      if (cfg_ok && cfg_sel && (int'(cfg_idx) < NUM_IGNORE)) begin
        ign_valid[cfg_idx[GW-1:0]] <= 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q       <= len_clamped;
            timer       <= '0;
            match_count <= '0;
            fail_code   <= FC_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
            if (len_clamped == '0) begin
              state   <= S_DONE;
              running <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              state   <= S_RUN;
              running <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (memwrite && addr_hit && data_hit) begin
            // A match in the expiry cycle still counts as a match.
            match_count <= match_count + CW'(1);
            timer       <= '0;
            if ((match_count + CW'(1)) == len_q) begin
              state   <= S_DONE;
              running <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end
          end else if (memwrite && addr_hit) begin
            state     <= S_DONE;
            running   <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_BAD_DATA;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (memwrite && !ign_hit) begin
            state     <= S_DONE;
            running   <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_BAD_ADDR;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else begin
            timer <= timer + TW'(1);
            if (expire) begin
              state     <= S_DONE;
              running   <= 1'b0;
              done      <= 1'b1;
              fail_code <= FC_TIMEOUT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
